sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 11 +
 rtl/sram_arbiter_timer.sv | 20 ++
 rtl/sram_arbiter.sv | 123 ++++++++++++
 tb/tb_sram_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared FSM state, owner encoding and default widths for the SRAM arbiter
package sram_arbiter_pkg;
  localparam int ADDR_W_DEF = 21;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_SNES, OWN_AVR} owner_t;
  // Strobe length clamped to the 1..15 range the 4-bit timer can count
  function automatic logic [3:0] wait_len(input int w);
    return (w < 1) ? 4'd1 : (w > 15) ? 4'd15 : 4'(w);
  endfunction
endpackage

// File: rtl/sram_arbiter_timer.sv
// sram_arbiter_timer: strobe-length down-counter; done marks the last strobe cycle
module sram_arbiter_timer
  import sram_arbiter_pkg::*;
#(
  parameter int WAIT_CYC = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic done
);
  localparam logic [3:0] LEN = wait_len(WAIT_CYC);
  logic [3:0] cnt;
  always_ff @(posedge clk) begin
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= LEN - 4'd1;
    else if (cnt != 4'd0) cnt <= cnt - 4'd1;
  end
  assign done = (cnt == 4'd0);
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: SNES/AVR arbiter for one async SRAM, IDLE/SETUP/STROBE/DONE access FSM
// SRAM_ARBITER_AUTOINC_EN adds avr_addr_ld and an auto-incrementing AVR address pointer.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              snes_mode,
  input  logic              snes_req,
  input  logic [ADDR_W-1:0] snes_addr,
  output logic [DATA_W-1:0] snes_rdata,
  output logic              snes_ack,
  input  logic              avr_req,
  input  logic              avr_we,
  input  logic [ADDR_W-1:0] avr_addr,
  input  logic [DATA_W-1:0] avr_wdata,
`ifdef SRAM_ARBITER_AUTOINC_EN
  input  logic              avr_addr_ld,
`endif
  output logic [DATA_W-1:0] avr_rdata,
  output logic              avr_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_dout_en,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              busy
);
  state_t state;
  owner_t owner;
  logic wr;
  logic done;
  logic grant_snes;
  logic [ADDR_W-1:0] avr_eff_addr;
`ifdef SRAM_ARBITER_AUTOINC_EN
  logic [ADDR_W-1:0] ptr;
  // Load beats the post-access increment when both land on the same edge
  always_ff @(posedge clk) begin
    if (!reset_n) ptr <= '0;
    else if (avr_addr_ld) ptr <= avr_addr;
    else if (state == DONE && owner == OWN_AVR) ptr <= ptr + 1'b1;
  end
  assign avr_eff_addr = ptr;
`else
  assign avr_eff_addr = avr_addr;
`endif
  assign grant_snes = snes_mode & snes_req;
  assign busy = (state != IDLE);
  sram_arbiter_timer #(.WAIT_CYC(WAIT_CYC)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (state == SETUP),
    .done   (done)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      owner        <= OWN_NONE;
      wr           <= 1'b0;
      sram_addr    <= '0;
      sram_dout    <= '0;
      sram_dout_en <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      snes_ack     <= 1'b0;
      avr_ack      <= 1'b0;
      snes_rdata   <= '0;
      avr_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_snes) begin
            state     <= SETUP;
            owner     <= OWN_SNES;
            wr        <= 1'b0;
            sram_addr <= snes_addr;
            sram_ce_n <= 1'b0;
          end else if (avr_req) begin
            state        <= SETUP;
            owner        <= OWN_AVR;
            wr           <= avr_we;
            sram_addr    <= avr_eff_addr;
            sram_dout_en <= avr_we;
            sram_ce_n    <= 1'b0;
            if (avr_we) sram_dout <= avr_wdata;
          end
        end
        SETUP: begin
          state     <= STROBE;
          sram_oe_n <= wr;
          sram_we_n <= ~wr;
        end
        STROBE: begin
          if (done) begin
            state     <= DONE;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            snes_ack  <= (owner == OWN_SNES);
            avr_ack   <= (owner == OWN_AVR);
            if (!wr && owner == OWN_SNES) snes_rdata <= sram_din;
            if (!wr && owner == OWN_AVR) avr_rdata <= sram_din;
          end
        end
        DONE: begin
          state        <= IDLE;
          owner        <= OWN_NONE;
          snes_ack     <= 1'b0;
          avr_ack      <= 1'b0;
          sram_dout_en <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed self-checking bench for sram_arbiter (WAIT_CYC=2)
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic snes_mode = 1'b0;
  logic snes_req = 1'b0;
  logic [20:0] snes_addr = '0;
  logic [7:0] snes_rdata;
  logic snes_ack;
  logic avr_req = 1'b0;
  logic avr_we = 1'b0;
  logic [20:0] avr_addr = '0;
  logic [7:0] avr_wdata = '0;
`ifdef SRAM_ARBITER_AUTOINC_EN
  logic avr_addr_ld = 1'b0;
`endif
  logic [7:0] avr_rdata;
  logic avr_ack;
  logic [20:0] sram_addr;
  logic [7:0] sram_dout;
  logic sram_dout_en;
  logic [7:0] sram_din = '0;
  logic sram_ce_n, sram_oe_n, sram_we_n, busy;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(21), .DATA_W(8), .WAIT_CYC(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .snes_mode   (snes_mode),
    .snes_req    (snes_req),
    .snes_addr   (snes_addr),
    .snes_rdata  (snes_rdata),
    .snes_ack    (snes_ack),
    .avr_req     (avr_req),
    .avr_we      (avr_we),
    .avr_addr    (avr_addr),
    .avr_wdata   (avr_wdata),
`ifdef SRAM_ARBITER_AUTOINC_EN
    .avr_addr_ld (avr_addr_ld),
`endif
    .avr_rdata   (avr_rdata),
    .avr_ack     (avr_ack),
    .sram_addr   (sram_addr),
    .sram_dout   (sram_dout),
    .sram_dout_en(sram_dout_en),
    .sram_din    (sram_din),
    .sram_ce_n   (sram_ce_n),
    .sram_oe_n   (sram_oe_n),
    .sram_we_n   (sram_we_n),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents an AVR request; with the pointer build the address is loaded one cycle earlier
  task automatic avr_start(input logic [20:0] a, input logic we, input logic [7:0] d);
    avr_addr = a;
    avr_we = we;
    avr_wdata = d;
`ifdef SRAM_ARBITER_AUTOINC_EN
    avr_addr_ld = 1'b1;
    step();
    avr_addr_ld = 1'b0;
`endif
    avr_req = 1'b1;
  endtask

  initial begin
    int sa, aa, viol, acks;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    chk("rst_acks", {snes_ack, avr_ack}, 0);
    chk("rst_dout", {sram_dout_en, sram_dout, sram_addr}, 0);
    chk("rst_rdata", {snes_rdata, avr_rdata}, 0);
    reset_n = 1'b1;
    step();

    // AVR write of 0xA5 to 0x012345
    avr_start(21'h012345, 1'b1, 8'hA5);
    step();
    avr_addr = '0;
    avr_wdata = 8'h00;
    chk("wr_setup_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b011);
    chk("wr_setup_bus", {sram_dout_en, sram_dout, sram_addr}, {1'b1, 8'hA5, 21'h012345});
    chk("wr_setup_busy", busy, 1);
    step();
    chk("wr_strobe1", {sram_ce_n, sram_oe_n, sram_we_n, avr_ack}, 4'b0100);
    step();
    chk("wr_strobe2", {sram_ce_n, sram_oe_n, sram_we_n, avr_ack}, 4'b0100);
    chk("wr_strobe2_bus", {sram_dout, sram_addr}, {8'hA5, 21'h012345});
    step();
    chk("wr_done", {sram_ce_n, sram_oe_n, sram_we_n, avr_ack, sram_dout_en}, 5'b11111);
    chk("wr_done_dout", sram_dout, 8'hA5);
    avr_req = 1'b0;
    step();
    chk("wr_idle", {avr_ack, busy, sram_dout_en}, 0);

    // SNES read of 0x000010 returning 0x3C
    snes_mode = 1'b1;
    snes_addr = 21'h000010;
    sram_din = 8'h3C;
    snes_req = 1'b1;
    step();
    chk("rd_setup", {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en}, 4'b0110);
    chk("rd_setup_addr", sram_addr, 21'h000010);
    step();
    chk("rd_strobe", {sram_oe_n, sram_we_n, sram_dout_en}, 3'b010);
    step();
    step();
    chk("rd_done", {snes_ack, avr_ack, snes_rdata}, {2'b10, 8'h3C});
    snes_req = 1'b0;
    sram_din = 8'h77;
    step();
    chk("rd_hold", {snes_ack, snes_rdata}, {1'b0, 8'h3C});

    // Simultaneous requests with SNES priority
    sram_din = 8'h99;
    avr_start(21'h000055, 1'b0, 8'h00);
    snes_req = 1'b1;
    sa = 0;
    aa = 0;
    viol = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if ((!sram_oe_n && !sram_we_n) || (sram_dout_en && !sram_oe_n)) viol++;
      if (snes_ack) begin
        sa = i;
        snes_req = 1'b0;
      end
      if (avr_ack) begin
        aa = i;
        avr_req = 1'b0;
      end
    end
    chk("pri_snes_cycle", sa, 4);
    chk("pri_avr_cycle", aa, 9);
    chk("pri_no_overlap", viol, 0);
    chk("pri_avr_rdata", avr_rdata, 8'h99);

    // SNES blocked while AVR owns the SRAM
    snes_mode = 1'b0;
    snes_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (snes_ack || busy) acks++;
    end
    chk("blocked_snes", acks, 0);
    snes_mode = 1'b1;
    step();
    chk("unblocked_setup", {busy, sram_ce_n}, 2'b10);
    step();
    step();
    step();
    chk("unblocked_ack", snes_ack, 1);
    snes_req = 1'b0;
    step();

    // Reset during the strobe of an AVR read
    avr_start(21'h000123, 1'b0, 8'h00);
    step();
    step();
    chk("mid_strobe_oe", sram_oe_n, 0);
    reset_n = 1'b0;
    step();
    chk("mid_rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    chk("mid_rst_state", {busy, avr_ack}, 0);
    chk("mid_rst_rdata", {snes_rdata, avr_rdata}, 0);
    reset_n = 1'b1;
    avr_req = 1'b0;
    step();
    chk("mid_rst_no_ack", {avr_ack, busy}, 0);

`ifdef SRAM_ARBITER_AUTOINC_EN
    // Pointer wraps from all-ones to zero after an AVR access
    avr_start(21'h1FFFFF, 1'b0, 8'h00);
    step();
    chk("inc_addr0", sram_addr, 21'h1FFFFF);
    step();
    step();
    step();
    chk("inc_ack0", avr_ack, 1);
    avr_req = 1'b0;
    step();
    avr_req = 1'b1;
    step();
    chk("inc_addr1", sram_addr, 21'h000000);
    avr_req = 1'b0;
    repeat (4) step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
